// File: rtl/count_source_pkg.sv
// count_source_pkg
// Shared definitions for the two-digit BCD count source: digit limit,
// controller state encoding and the default prescaler settings.
package count_source_pkg;

  localparam logic [3:0] BCD_MAX            = 4'd9;
  localparam int         PRESCALE_DEFAULT   = 50000;
  localparam int         PRESCALE_W_DEFAULT = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

endpackage

// File: rtl/count_source_bcd_digit.sv
// bcd_digit
// One BCD digit (0..9) that steps up or down when enabled and wraps at
// the ends, reporting the wrap as carry (up) or borrow (down).
// Ports:
//   clk   - system clock
//   rst   - synchronous reset, active low
//   en    - step this digit in the current cycle
//   up    - direction of the step: 1 up, 0 down
//   clr   - synchronous clear to 0, wins over en
//   digit - current digit value
//   carry - this step wraps the digit (9->0 up, 0->9 down)
module bcd_digit
  import count_source_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else if (en) begin
      // Out-of-range codes fold back into 0..9 on the next step.
      if (up) digit <= (digit >= BCD_MAX) ? 4'd0 : digit + 4'd1;
      else    digit <= (digit == 4'd0 || digit > BCD_MAX) ? BCD_MAX : digit - 4'd1;
    end
  end

  assign carry = en & ~clr & (up ? (digit == BCD_MAX) : (digit == 4'd0));

endmodule

// File: rtl/count_source.sv
// count_source
// Two-digit BCD up/down counter advanced by a free-running prescaler.
// The prescaler only runs in RUN; each terminal count produces Tick and
// steps the digits one cycle later. Update pulses one cycle after the
// displayed digits change.
// Optional macro COUNT_SOURCE_HOLD_EN adds input Hold, which freezes the
// displayed digits while the internal count keeps going.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous reset, active low
//   Enable   - counting permitted while high
//   Up_Down  - direction: 1 up, 0 down (sampled at Tick)
//   Clear    - synchronous clear of both digits and the prescaler
//   Hold     - (COUNT_SOURCE_HOLD_EN only) freeze displayed digits
//   Count_F  - BCD units digit
//   Count_CT - BCD tens digit
//   Tick     - one-cycle pulse at prescaler terminal count in RUN
//   Update   - one-cycle pulse in the cycle after the digits change
//
// state | meaning
// IDLE  | after reset, digits and prescaler at 0, waiting for Enable
// RUN   | prescaler counting, digits step on each Tick
// PAUSE | Enable low, prescaler and digits hold their values
module count_source
  import count_source_pkg::*;
#(
  parameter int PRESCALE   = PRESCALE_DEFAULT,
  parameter int PRESCALE_W = PRESCALE_W_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Enable,
  input  logic       Up_Down,
  input  logic       Clear,
`ifdef COUNT_SOURCE_HOLD_EN
  input  logic       Hold,
`endif
  output logic [3:0] Count_F,
  output logic [3:0] Count_CT,
  output logic       Tick,
  output logic       Update
);

  localparam logic [PRESCALE_W-1:0] PRE_TC = PRESCALE_W'(PRESCALE - 1);

  state_t                state;
  state_t                state_nxt;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  advance;
  logic                  pre_tc;
  logic [3:0]            units;
  logic [3:0]            tens;
  logic                  units_carry;
  logic                  tens_carry_unused;
  logic [3:0]            prev_f;
  logic [3:0]            prev_ct;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Clear freezes the state as well as zeroing the count.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Enable && !Clear)  state_nxt = RUN;
      RUN:     if (!Enable && !Clear) state_nxt = PAUSE;
      PAUSE:   if (Enable && !Clear)  state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    advance = (state == RUN) && Enable && !Clear;
    pre_tc  = (pre_cnt == PRE_TC);
    Tick    = advance && pre_tc && rst;
  end

  always_ff @(posedge clk) begin
    if (!rst || Clear) begin
      pre_cnt <= '0;
    end else if (advance) begin
      pre_cnt <= pre_tc ? '0 : pre_cnt + PRESCALE_W'(1);
    end
  end

  bcd_digit u_units (
    .clk   (clk),
    .rst   (rst),
    .en    (Tick),
    .up    (Up_Down),
    .clr   (Clear),
    .digit (units),
    .carry (units_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .rst   (rst),
    .en    (units_carry),
    .up    (Up_Down),
    .clr   (Clear),
    .digit (tens),
    .carry (tens_carry_unused)
  );

`ifdef COUNT_SOURCE_HOLD_EN
  logic       hold_q;
  logic [3:0] frz_f;
  logic [3:0] frz_ct;

  // The snapshot tracks the live digits until Hold is registered, so the
  // display freezes on the value shown when Hold was raised and picks up
  // the live value one cycle after Hold falls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q <= 1'b0;
      frz_f  <= 4'd0;
      frz_ct <= 4'd0;
    end else begin
      hold_q <= Hold;
      if (!hold_q) begin
        frz_f  <= units;
        frz_ct <= tens;
      end
    end
  end

  assign Count_F  = hold_q ? frz_f  : units;
  assign Count_CT = hold_q ? frz_ct : tens;
`else
  assign Count_F  = units;
  assign Count_CT = tens;
`endif

  // Comparing against last cycle's display places Update one cycle after
  // the visible change, and a clear of already-zero digits stays silent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_f  <= 4'd0;
      prev_ct <= 4'd0;
      Update  <= 1'b0;
    end else begin
      prev_f  <= Count_F;
      prev_ct <= Count_CT;
      Update  <= (Count_F != prev_f) || (Count_CT != prev_ct);
    end
  end

endmodule
